// File: rtl/axi_wid_pkg.sv
// axi_wid_pkg: shared ID width default, pointer-width helper and ID type for the AXI3 wid regenerator
package axi_wid_pkg;
    localparam int ID_W_DEF = 4;

    typedef logic [ID_W_DEF-1:0] axi_id_t;

    // Pointer width for a DEPTH-entry ring; a single-entry FIFO still needs a 1-bit pointer
    function automatic int clog2_depth(input int d);
        return (d <= 1) ? 1 : $clog2(d);
    endfunction
endpackage

// File: rtl/axi_id_fifo.sv
// axi_id_fifo: synchronous ID FIFO with asynchronous reset and exact occupancy count
//   clk, rst      : clock, async active-high reset
//   push, pop     : write / read strobes (ignored when full / empty respectively)
//   din, dout     : write data, head entry (0 when empty)
//   full, empty   : occupancy flags derived from the registered count
//   count         : number of stored entries, 0..DEPTH
module axi_id_fifo
    import axi_wid_pkg::*;
#(
    parameter int ID_W  = ID_W_DEF,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = clog2_depth(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [ID_W-1:0] din,
    output logic [ID_W-1:0] dout,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count
);
    logic [ID_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Stale data stays in the ring after a pop; the head reads as 0 when nothing is open
    assign dout    = empty ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = do_push ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d  = do_pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= din;
        end
    end
endmodule

// File: rtl/axi3_wid_gen.sv
// axi3_wid_gen: regenerates AXI3 wid from the order of accepted AW IDs
//   aclk, global_reset             : clock, async active-high reset
//   s_awid/s_awvalid/s_awready     : AW from core
//   m_awvalid/m_awready            : AW to bridge
//   s_wvalid/s_wlast/s_wready      : W from core
//   m_wvalid/m_wready/m_wid        : W to bridge with regenerated ID
//   bid/bvalid/bready              : B channel, observed only
//   wr_open                        : AW bursts still awaiting W completion
//   bchk_err/bchk_err_id           : sticky B-order error and first offending bid
// Optional: AXI_WID_BCHK_EN adds a completed-burst ID FIFO that checks B ordering.
module axi3_wid_gen
    import axi_wid_pkg::*;
#(
    parameter int ID_W  = ID_W_DEF,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            aclk,
    input  logic            global_reset,
    input  logic [ID_W-1:0] s_awid,
    input  logic            s_awvalid,
    output logic            s_awready,
    output logic            m_awvalid,
    input  logic            m_awready,
    input  logic            s_wvalid,
    input  logic            s_wlast,
    output logic            s_wready,
    output logic            m_wvalid,
    input  logic            m_wready,
    output logic [ID_W-1:0] m_wid,
    input  logic [ID_W-1:0] bid,
    input  logic            bvalid,
    input  logic            bready,
    output logic [CW-1:0]   wr_open,
    output logic            bchk_err,
    output logic [ID_W-1:0] bchk_err_id
);
    logic full, empty, w_block, aw_push, w_pop;

    // full comes from registered count, so a same-cycle pop never opens AW
    assign m_awvalid = s_awvalid & ~full;
    assign s_awready = m_awready & ~full;
    assign aw_push   = m_awvalid & m_awready;
    assign m_wvalid  = s_wvalid & ~w_block;
    assign s_wready  = m_wready & ~w_block;
    assign w_pop     = m_wvalid & m_wready & s_wlast;

    axi_id_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) u_aw_fifo (
        .clk   (aclk),
        .rst   (global_reset),
        .push  (aw_push),
        .pop   (w_pop),
        .din   (s_awid),
        .dout  (m_wid),
        .full  (full),
        .empty (empty),
        .count (wr_open)
    );

`ifdef AXI_WID_BCHK_EN
    logic            b_full, b_empty, b_hs, b_bad;
    logic [ID_W-1:0] b_head;
    logic [CW-1:0]   unused_bcnt;
    logic            err_q, err_d;
    logic [ID_W-1:0] err_id_q, err_id_d;

    // A last beat may only leave if its ID has room to wait for the matching B
    assign w_block = empty | (s_wlast & b_full);
    assign b_hs    = bvalid & bready;
    assign b_bad   = b_hs & (b_empty | (bid != b_head));

    axi_id_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) u_b_fifo (
        .clk   (aclk),
        .rst   (global_reset),
        .push  (w_pop),
        .pop   (b_hs),
        .din   (m_wid),
        .dout  (b_head),
        .full  (b_full),
        .empty (b_empty),
        .count (unused_bcnt)
    );

    always_comb begin
        err_d    = err_q | b_bad;
        err_id_d = (b_bad & ~err_q) ? bid : err_id_q;
    end

    always_ff @(posedge aclk or posedge global_reset) begin
        if (global_reset) begin
            err_q    <= 1'b0;
            err_id_q <= '0;
        end else begin
            err_q    <= err_d;
            err_id_q <= err_id_d;
        end
    end

    assign bchk_err    = err_q;
    assign bchk_err_id = err_id_q;
`else
    logic unused_b;

    assign w_block     = empty;
    assign unused_b    = ^{bid, bvalid, bready};
    assign bchk_err    = 1'b0;
    assign bchk_err_id = '0;
`endif
endmodule
